// File: rtl/nandy_pkg.sv
// Shared types and constants for the nandy fetch/execute front end.
package nandy_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC0 = 2'b01,
    EXEC1 = 2'b10
  } state_t;

  localparam int INST_W = 8;
  localparam logic [INST_W-1:0] INST_NOP = 8'h00;

endpackage

// File: rtl/pc_reg.sv
// Program counter: synchronous reset, increments or loads a jump target at end of instruction.
module pc_reg #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  // Increment wraps naturally at the register width.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (adv)
      pc <= jump ? target : pc + 1'b1;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: owns PC, instruction register and carry; drives the control decoder.
//
//  state | meaning
//  FETCH | request byte at pc, wait for imem_valid
//  EXEC0 | first execution cycle (cycle=0)
//  EXEC1 | second execution cycle of an MC instruction (cycle=1)
module fetch_sequencer
  import nandy_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  input  logic              imem_valid,
  output logic [INST_W-1:0] inst,
  output logic              cycle,
  output logic              carry,
  output logic              exec,
  input  logic              ctl_mc,
  input  logic              ctl_j,
  input  logic              ctl_wc,
  input  logic              alu_carry,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc
);

  state_t state;
  logic   end_instr;

  // MC in EXEC0 defers the end of instruction, so a jump there is never taken.
  assign end_instr = (state == EXEC1) || (state == EXEC0 && !ctl_mc);
  assign imem_addr = pc;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .adv   (end_instr),
    .jump  (ctl_j),
    .target(jump_target),
    .pc    (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      inst     <= INST_NOP;
      carry    <= 1'b0;
      imem_req <= 1'b1;
      exec     <= 1'b0;
      cycle    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_valid) begin
            inst     <= imem_data;
            state    <= EXEC0;
            imem_req <= 1'b0;
            exec     <= 1'b1;
            cycle    <= 1'b0;
          end
        end
        EXEC0: begin
          if (ctl_mc) begin
            state <= EXEC1;
            cycle <= 1'b1;
          end else begin
            state    <= FETCH;
            imem_req <= 1'b1;
            exec     <= 1'b0;
            cycle    <= 1'b0;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          exec     <= 1'b0;
          cycle    <= 1'b0;
        end
      endcase
      if (state != FETCH && ctl_wc)
        carry <= alu_carry;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with a bounded hand-written wait sequence.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [7:0]  imem_data;
  logic        imem_valid;
  logic [7:0]  inst;
  logic        cycle;
  logic        carry;
  logic        exec;
  logic        ctl_mc;
  logic        ctl_j;
  logic        ctl_wc;
  logic        alu_carry;
  logic [15:0] jump_target;
  logic [15:0] pc;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .inst       (inst),
    .cycle      (cycle),
    .carry      (carry),
    .exec       (exec),
    .ctl_mc     (ctl_mc),
    .ctl_j      (ctl_j),
    .ctl_wc     (ctl_wc),
    .alu_carry  (alu_carry),
    .jump_target(jump_target),
    .pc         (pc)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        mc;
    logic        j;
    logic        wc;
    logic        alu;
    logic [15:0] target;
    logic        e_req;
    logic        e_exec;
    logic        e_cyc;
    logic [7:0]  e_inst;
    logic        e_carry;
    logic [15:0] e_addr;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic mc, input logic j,
                     input logic wc, input logic alu, input logic [15:0] tgt,
                     input logic req, input logic ex, input logic cy, input logic [7:0] in,
                     input logic ca, input logic [15:0] ad);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.mc = mc; x.j = j; x.wc = wc; x.alu = alu; x.target = tgt;
    x.e_req = req; x.e_exec = ex; x.e_cyc = cy; x.e_inst = in; x.e_carry = ca; x.e_addr = ad;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic mc,
                       input logic j, input logic wc, input logic alu, input logic [15:0] tgt);
    rst = r; imem_valid = v; imem_data = d; ctl_mc = mc; ctl_j = j;
    ctl_wc = wc; alu_carry = alu; jump_target = tgt;
  endtask

  task automatic check_all(input int idx, input logic req, input logic ex, input logic cy,
                           input logic [7:0] in, input logic ca, input logic [15:0] ad);
    chk("imem_req",  idx, {31'd0, imem_req}, {31'd0, req});
    chk("exec",      idx, {31'd0, exec},     {31'd0, ex});
    chk("cycle",     idx, {31'd0, cycle},    {31'd0, cy});
    chk("inst",      idx, {24'd0, inst},     {24'd0, in});
    chk("carry",     idx, {31'd0, carry},    {31'd0, ca});
    chk("imem_addr", idx, {16'd0, imem_addr}, {16'd0, ad});
    chk("pc",        idx, {16'd0, pc},       {16'd0, ad});
  endtask

  initial begin
    //   rst v  data   mc j  wc alu target     req ex cy inst   ca addr
    add(1, 0, 8'h00, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 8'h00, 0, 16'h0000);
    add(1, 1, 8'hAA, 0, 0, 1, 1, 16'h0000,  1, 0, 0, 8'h00, 0, 16'h0000);
    add(0, 1, 8'h15, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 8'h15, 0, 16'h0000);
    add(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 8'h15, 0, 16'h0001);
    add(0, 1, 8'h80, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 8'h80, 0, 16'h0001);
    add(0, 0, 8'h00, 1, 1, 0, 0, 16'h1234,  0, 1, 1, 8'h80, 0, 16'h0001);
    add(0, 0, 8'h00, 1, 0, 0, 0, 16'h0000,  1, 0, 0, 8'h80, 0, 16'h0002);
    add(0, 1, 8'hC3, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 8'hC3, 0, 16'h0002);
    add(0, 0, 8'h00, 0, 1, 0, 0, 16'hFFFF,  1, 0, 0, 8'hC3, 0, 16'hFFFF);
    add(0, 1, 8'h01, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 8'h01, 0, 16'hFFFF);
    add(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 8'h01, 0, 16'h0000);
    add(0, 0, 8'hEE, 0, 0, 1, 1, 16'h0000,  1, 0, 0, 8'h01, 0, 16'h0000);
    add(0, 0, 8'hEE, 0, 0, 1, 1, 16'h0000,  1, 0, 0, 8'h01, 0, 16'h0000);
    add(0, 0, 8'hEE, 0, 0, 1, 1, 16'h0000,  1, 0, 0, 8'h01, 0, 16'h0000);
    add(0, 1, 8'h42, 0, 0, 1, 1, 16'h0000,  0, 1, 0, 8'h42, 0, 16'h0000);
    add(0, 0, 8'h00, 0, 0, 1, 1, 16'h0000,  1, 0, 0, 8'h42, 1, 16'h0001);
    add(0, 1, 8'h10, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 8'h10, 1, 16'h0001);
    add(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 8'h10, 1, 16'h0002);
    add(0, 1, 8'h20, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 8'h20, 1, 16'h0002);
    add(0, 0, 8'h00, 1, 0, 0, 0, 16'h0000,  0, 1, 1, 8'h20, 1, 16'h0002);
    add(0, 0, 8'h00, 0, 1, 1, 0, 16'h0100,  1, 0, 0, 8'h20, 0, 16'h0100);
    add(0, 1, 8'h81, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 8'h81, 0, 16'h0100);
    add(0, 0, 8'h00, 1, 0, 1, 1, 16'h0000,  0, 1, 1, 8'h81, 1, 16'h0100);
    add(1, 0, 8'h00, 0, 1, 1, 1, 16'h5555,  1, 0, 0, 8'h00, 0, 16'h0000);
    add(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000,  1, 0, 0, 8'h00, 0, 16'h0000);

    drive(1, 0, 8'h00, 0, 0, 0, 0, 16'h0000);
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].mc, vecs[i].j,
            vecs[i].wc, vecs[i].alu, vecs[i].target);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_req, vecs[i].e_exec, vecs[i].e_cyc,
                vecs[i].e_inst, vecs[i].e_carry, vecs[i].e_addr);
      @(negedge clk);
    end

    // Hand sequence: two wait cycles, then a bounded wait for exec after the response.
    begin
      int  budget;
      logic seen;
      drive(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000);
      repeat (2) @(negedge clk);
      chk("wait_addr_hold", 100, {16'd0, imem_addr}, 32'h0000_0000);
      drive(0, 1, 8'h33, 0, 0, 0, 0, 16'h0000);
      seen = 1'b0;
      budget = 4;
      while (!seen && budget > 0) begin
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_data  = 8'h00;
        if (exec) seen = 1'b1;
        budget--;
      end
      chk("exec_reached", 101, {31'd0, seen}, 32'd1);
      chk("inst_33", 102, {24'd0, inst}, 32'h33);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk("next_addr", 103, {16'd0, imem_addr}, 32'h0001);
      chk("req_back", 104, {31'd0, imem_req}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequential front end that drives the combinational `control` decoder. It owns the program counter, instruction register, `cycle` bit and carry flag. It fetches one instruction byte per instruction over a valid-handshake instruction-memory port. It sequences one- or two-cycle execution from the decoder's `MC`, `J` and `WC` outputs and the ALU carry.

## Interface
Parameters:
- `ADDR_W`, 16: program counter / instruction address width.
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  fetch request; high exactly while in FETCH.
- `imem_addr`  out  ADDR_W  fetch address; equals PC.
- `imem_data`  in  8  instruction byte; sampled only when `imem_req && imem_valid`.
- `imem_valid`  in  1  memory response strobe; any number of wait cycles allowed.
- `inst`  out  8  instruction register, fed to the decoder.
- `cycle`  out  1  execution cycle index (0 = first, 1 = second), fed to the decoder.
- `carry`  out  1  carry flag register, fed to the decoder.
- `exec`  out  1  high in EXEC0/EXEC1; architectural writes elsewhere are gated by it.
- `ctl_mc`  in  1  decoder MC: instruction needs a second cycle.
- `ctl_j`  in  1  decoder J: take jump at end of instruction.
- `ctl_wc`  in  1  decoder WC: write carry this cycle.
- `alu_carry`  in  1  ALU carry-out.
- `jump_target`  in  ADDR_W  jump destination, valid while `ctl_j`.
- `pc`  out  ADDR_W  current program counter (debug / link value for LJ).

## Operation
- States: FETCH, EXEC0, EXEC1.
- FETCH:
  - `imem_req=1`, `exec=0`, `cycle=0`.
  - On `imem_valid`: `inst <= imem_data`, go to EXEC0.
  - Otherwise hold state; nothing else changes.
- EXEC0:
  - `exec=1`, `cycle=0`.
  - If `ctl_mc`: go to EXEC1. PC and `inst` hold; `ctl_j` is ignored this cycle.
  - Else the instruction ends (see below) and the state goes to FETCH.
- EXEC1:
  - `exec=1`, `cycle=1`.
  - The instruction always ends; next state FETCH.
  - `ctl_mc` is ignored (no third cycle).
- End of instruction: `pc <= ctl_j ? jump_target : pc + 1`, modulo 2^ADDR_W (0xFFFF+1 wraps to 0x0000 at ADDR_W=16).
- Carry: in EXEC0 or EXEC1 with `ctl_wc=1`, `carry <= alu_carry`. In FETCH, `ctl_wc` is ignored. Carry persists across instructions.
- `inst` changes only on an accepted fetch. `cycle` is a decode of state, not separate storage.
- Reset values:
  - state FETCH; `pc=RESET_PC`; `inst=8'h00`; `carry=0`.
  - Outputs: `cycle=0`, `exec=0`, `imem_req=1`, `imem_addr=RESET_PC`.
- Reset in any state, including EXEC1 or mid-wait, aborts the instruction. It applies no PC or carry update that cycle. `imem_valid` coincident with `rst` is dropped.

## Timing
- Minimum instruction time: 2 clocks for single-cycle, 3 clocks for two-cycle (1 FETCH + exec cycles), plus memory wait cycles.
- Fetch latency: `inst` is valid the cycle after `imem_valid` is sampled high.
- `imem_addr` is stable for the whole FETCH wait.
- The memory must hold `imem_data` valid in the `imem_valid` cycle only.
- Decoder inputs (`inst`, `cycle`, `carry`) are registered outputs with no combinational path from `imem_*`.
- `ctl_*` inputs are sampled on the same edge that leaves the exec state. Their combinational path from `inst`/`cycle` through the decoder is one cycle.
- `ctl_wc` and `ctl_j` in the same final cycle both take effect. A jump taken in EXEC0 of a two-cycle instruction is impossible, because MC wins.

## Structure
- Shared package `nandy_pkg`:
  - state encoding enum (FETCH=2'b00, EXEC0=2'b01, EXEC1=2'b10)
  - `INST_W=8`
  - reset instruction constant `INST_NOP=8'h00`
- One natural sub-module: `pc_reg` (ADDR_W register with synchronous reset to RESET_PC, increment and load-on-jump).
- Everything else stays inline.

## Test plan
- Reset/fetch:
  - Stimulus: hold `rst` 2 cycles, then `imem_valid=1`, `imem_data=8'h15`, `ctl_mc=0`.
  - Required: during reset `imem_addr=0000`, `inst=00`, `carry=0`. One cycle later `inst=15`, `exec=1`, `cycle=0`. Then `imem_addr=0001`.
- Two-cycle instruction:
  - Stimulus: fetch `8'h80`, `ctl_mc=1` in EXEC0.
  - Required: `cycle` reads 0 then 1; PC is unchanged until after EXEC1; next `imem_addr=pc+1`.
- Jump and wrap:
  - Stimulus: `ctl_j=1`, `jump_target=16'hFFFF`; then a non-jump instruction.
  - Required: next fetch at FFFF, the following fetch at 0000.
- Wait states and carry:
  - Stimulus: `imem_valid` low 3 cycles in FETCH, with `ctl_wc=1` and `alu_carry=1` during the wait.
  - Required: carry stays 0 and `imem_addr` is held. After the fetch, in EXEC0, `ctl_wc=1` sets carry to 1, and carry is still 1 two instructions later.
- Reset mid-operation:
  - Stimulus: assert `rst` in EXEC1 with `ctl_j=1` and `ctl_wc=1`.
  - Required: next cycle state FETCH, `pc=RESET_PC`, `carry=0`, `inst=00`, no jump taken.
